// File: rtl/median_filter.sv
// 3x3 median filter for an 8-bit camera-style luma stream (vsync/href/data).
// Sync and pixels leave together, a fixed four clocks after they arrive.
module median_filter #(
  parameter int IMG_WIDTH = 640,
  parameter int LATENCY   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       per_frame_vsync,
  input  logic       per_frame_href,
  input  logic [7:0] per_img_y,
  output logic       pos_frame_vsync,
  output logic       pos_frame_href,
  output logic [7:0] pos_img_y
);

  localparam int               COL_W   = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_WIDTH - 1);

  function automatic logic [7:0] max2(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [7:0] min2(input logic [7:0] a, input logic [7:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [7:0] max3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    return max2(max2(a, b), c);
  endfunction

  function automatic logic [7:0] min3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    return min2(min2(a, b), c);
  endfunction

  function automatic logic [7:0] mid3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    return max2(min2(a, b), min2(max2(a, b), c));
  endfunction

  logic [7:0]         buf1_mem [IMG_WIDTH];
  logic [7:0]         buf2_mem [IMG_WIDTH];

  logic [COL_W-1:0]   col_q, col_d;
  logic               over_q, over_d;
  logic [1:0]         row_q, row_d;
  logic [LATENCY-1:0] vs_pipe_q, vs_pipe_d;
  logic [LATENCY-1:0] hr_pipe_q, hr_pipe_d;
  // win[row][col]: row 0 = r-2 .. row 2 = current line; col 0 = c-2 .. col 2 = c
  logic [2:0][2:0][7:0] win_q, win_d;
  logic [2:0][7:0]    row_min_q, row_min_d;
  logic [2:0][7:0]    row_mid_q, row_mid_d;
  logic [2:0][7:0]    row_max_q, row_max_d;
  logic [7:0]         max_min_q, max_min_d;
  logic [7:0]         med_mid_q, med_mid_d;
  logic [7:0]         min_max_q, min_max_d;
  logic [7:0]         img_q, img_d;

  logic               vs_rise_s;
  logic               hr_fall_s;
  logic               ram_we_s;
  logic [7:0]         mid_rd_s;
  logic [7:0]         top_rd_s;
  logic [7:0]         mid_px_s;
  logic [7:0]         top_px_s;

  // The first pipe stage doubles as the previous-cycle sample for edge detection.
  assign vs_rise_s = per_frame_vsync & ~vs_pipe_q[0];
  assign hr_fall_s = ~per_frame_href & hr_pipe_q[0];
  assign ram_we_s  = per_frame_href & ~over_q;
  assign mid_rd_s  = buf1_mem[col_q];
  assign top_rd_s  = buf2_mem[col_q];
  assign mid_px_s  = ((row_q != 2'd0) && !over_q) ? mid_rd_s : 8'd0;
  assign top_px_s  = ((row_q == 2'd2) && !over_q) ? top_rd_s : 8'd0;

  // Line buffers: read-before-write, previous line shifts from buf1 into buf2.
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      buf1_mem[col_q] <= per_img_y;
      buf2_mem[col_q] <= mid_rd_s;
    end
  end

  // Next-state logic for counters, window and the sorting pipeline.
  always_comb begin
    vs_pipe_d = {vs_pipe_q[LATENCY-2:0], per_frame_vsync};
    hr_pipe_d = {hr_pipe_q[LATENCY-2:0], per_frame_href};

    if (per_frame_href) begin
      if (col_q == COL_MAX) begin
        col_d  = col_q;
        over_d = 1'b1;
      end else begin
        col_d  = col_q + COL_W'(1);
        over_d = over_q;
      end
    end else if (hr_fall_s) begin
      col_d  = '0;
      over_d = 1'b0;
    end else begin
      col_d  = col_q;
      over_d = over_q;
    end

    if (vs_rise_s) begin
      row_d = 2'd0;
    end else if (hr_fall_s && (row_q != 2'd2)) begin
      row_d = row_q + 2'd1;
    end else begin
      row_d = row_q;
    end

    // Idle cycles empty the window so each line starts with a zero left border.
    if (per_frame_href) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = top_px_s;
      win_d[1][2] = mid_px_s;
      win_d[2][2] = per_img_y;
    end else begin
      win_d = '0;
    end

    for (int r = 0; r < 3; r++) begin
      row_min_d[r] = min3(win_q[r][0], win_q[r][1], win_q[r][2]);
      row_mid_d[r] = mid3(win_q[r][0], win_q[r][1], win_q[r][2]);
      row_max_d[r] = max3(win_q[r][0], win_q[r][1], win_q[r][2]);
    end

    max_min_d = max3(row_min_q[0], row_min_q[1], row_min_q[2]);
    med_mid_d = mid3(row_mid_q[0], row_mid_q[1], row_mid_q[2]);
    min_max_d = min3(row_max_q[0], row_max_q[1], row_max_q[2]);

    if (hr_pipe_q[LATENCY-2]) begin
      img_d = mid3(max_min_q, med_mid_q, min_max_q);
    end else begin
      img_d = 8'd0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q     <= '0;
      over_q    <= 1'b0;
      row_q     <= 2'd0;
      vs_pipe_q <= '0;
      hr_pipe_q <= '0;
      win_q     <= '0;
      row_min_q <= '0;
      row_mid_q <= '0;
      row_max_q <= '0;
      max_min_q <= 8'd0;
      med_mid_q <= 8'd0;
      min_max_q <= 8'd0;
      img_q     <= 8'd0;
    end else begin
      col_q     <= col_d;
      over_q    <= over_d;
      row_q     <= row_d;
      vs_pipe_q <= vs_pipe_d;
      hr_pipe_q <= hr_pipe_d;
      win_q     <= win_d;
      row_min_q <= row_min_d;
      row_mid_q <= row_mid_d;
      row_max_q <= row_max_d;
      max_min_q <= max_min_d;
      med_mid_q <= med_mid_d;
      min_max_q <= min_max_d;
      img_q     <= img_d;
    end
  end

  assign pos_frame_vsync = vs_pipe_q[LATENCY-1];
  assign pos_frame_href  = hr_pipe_q[LATENCY-1];
  assign pos_img_y       = img_q;

endmodule

// File: tb/tb_median_filter.sv
// Randomized bench for median_filter: zero-padded 3x3 median reference model,
// sync delay history and per-frame pixel count checks.
module tb_median_filter;

  localparam int W = 640;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       per_frame_vsync;
  logic       per_frame_href;
  logic [7:0] per_img_y;
  logic       pos_frame_vsync;
  logic       pos_frame_href;
  logic [7:0] pos_img_y;

  always #5 clk = ~clk;

  median_filter #(.IMG_WIDTH(W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .per_frame_vsync (per_frame_vsync),
    .per_frame_href  (per_frame_href),
    .per_img_y       (per_img_y),
    .pos_frame_vsync (pos_frame_vsync),
    .pos_frame_href  (pos_frame_href),
    .pos_img_y       (pos_img_y)
  );

  logic [7:0] frame   [8][W];
  logic [7:0] out_img [8][W];
  logic [7:0] exp_q[$];
  logic [7:0] e_v;
  logic [1:0] hist [4];
  int         n_chk = 0;
  int         n_err = 0;
  int         out_cnt = 0;
  int         out_max = 0;
  int         cur_cols = 16;
  bit         chk_en = 1'b1;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Zero-padded 3x3 median centred one row up and one column left of (r,k).
  function automatic logic [7:0] ref_median(input int r, input int k);
    int vals[$];
    for (int dr = -2; dr <= 0; dr++) begin
      for (int dk = -2; dk <= 0; dk++) begin
        if ((r + dr) < 0 || (k + dk) < 0) vals.push_back(0);
        else vals.push_back(int'(frame[r+dr][k+dk]));
      end
    end
    vals.sort();
    return 8'(vals[4]);
  endfunction

  always @(negedge rst_n) begin
    for (int i = 0; i < 4; i++) hist[i] = 2'b00;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) hist[i] = 2'b00;
    end else begin
      hist[3] = hist[2];
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = {per_frame_vsync, per_frame_href};
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("vsync_delay", int'(pos_frame_vsync), int'(hist[3][1]));
      check("href_delay", int'(pos_frame_href), int'(hist[3][0]));
      if (pos_frame_href) begin
        if (chk_en) begin
          check("sb_nonempty", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e_v = exp_q.pop_front();
            check("pixel", int'(pos_img_y), int'(e_v));
          end
          if (out_cnt < 8 * cur_cols) out_img[out_cnt / cur_cols][out_cnt % cur_cols] = pos_img_y;
          if (int'(pos_img_y) > out_max) out_max = int'(pos_img_y);
          out_cnt++;
        end
      end else begin
        check("idle_zero", int'(pos_img_y), 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int mode, input int v);
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < W; k++) begin
        if (mode == 0) frame[r][k] = 8'(v);
        else frame[r][k] = 8'($urandom_range(255, 0));
      end
    end
  endtask

  task automatic drive_line(input int r, input int cols, input int hb);
    for (int k = 0; k < cols; k++) begin
      step();
      per_frame_href = 1'b1;
      per_img_y      = frame[r][k];
      exp_q.push_back(ref_median(r, k));
    end
    step();
    per_frame_href = 1'b0;
    per_img_y      = 8'd0;
    repeat (hb) step();
  endtask

  task automatic start_frame(input int cols);
    out_cnt  = 0;
    out_max  = 0;
    cur_cols = cols;
    step();
    per_frame_vsync = 1'b1;
    repeat (2) step();
    per_frame_vsync = 1'b0;
    repeat (4) step();
  endtask

  // hb < 0 selects a random horizontal blank per line.
  task automatic drive_frame(input int rows, input int cols, input int hb);
    start_frame(cols);
    for (int r = 0; r < rows; r++) begin
      drive_line(r, cols, (hb < 0) ? int'($urandom_range(12, 1)) : hb);
    end
    repeat (8) step();
    check("href_count", out_cnt, rows * cols);
    check("sb_drain", exp_q.size(), 0);
  endtask

  initial begin
    rst_n           = 1'b0;
    per_frame_vsync = 1'b0;
    per_frame_href  = 1'b0;
    per_img_y       = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_vsync", int'(pos_frame_vsync), 0);
    check("rst_href", int'(pos_frame_href), 0);
    check("rst_y", int'(pos_img_y), 0);
    #2 rst_n = 1'b1;

    fill(0, 100);
    drive_frame(8, 16, 6);
    check("flat_inner", int'(out_img[5][5]), 100);
    check("flat_corner", int'(out_img[0][0]), 0);

    fill(0, 0);
    frame[4][4] = 8'd255;
    drive_frame(8, 16, 3);
    check("impulse_max", out_max, 0);

    fill(1, 0);
    frame[0][0] = 8'd9; frame[0][1] = 8'd1; frame[0][2] = 8'd5;
    frame[1][0] = 8'd3; frame[1][1] = 8'd7; frame[1][2] = 8'd2;
    frame[2][0] = 8'd8; frame[2][1] = 8'd4; frame[2][2] = 8'd6;
    drive_frame(8, 16, -1);
    check("pattern_med", int'(out_img[2][2]), 5);

    for (int f = 0; f < 3; f++) begin
      fill(1, 0);
      drive_frame(8, 16, -1);
    end

    // Arbitrary sync toggling: only delay alignment and idle-zero are checked.
    chk_en = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      per_frame_vsync = 1'($urandom_range(1, 0));
      per_frame_href  = 1'($urandom_range(1, 0));
      per_img_y       = 8'($urandom_range(255, 0));
    end
    step();
    per_frame_vsync = 1'b0;
    per_frame_href  = 1'b0;
    per_img_y       = 8'd0;
    repeat (6) step();
    chk_en = 1'b1;

    // Reset in the middle of a line, then a clean frame.
    fill(1, 0);
    start_frame(16);
    for (int r = 0; r < 3; r++) drive_line(r, 16, 5);
    for (int k = 0; k < 6; k++) begin
      step();
      per_frame_href = 1'b1;
      per_img_y      = frame[3][k];
      exp_q.push_back(ref_median(3, k));
    end
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_href", int'(pos_frame_href), 0);
    check("rst_mid_vsync", int'(pos_frame_vsync), 0);
    check("rst_mid_y", int'(pos_img_y), 0);
    exp_q.delete();
    per_frame_href = 1'b0;
    per_img_y      = 8'd0;
    repeat (3) step();
    #2 rst_n = 1'b1;
    fill(1, 0);
    drive_frame(8, 16, -1);

    for (int f = 0; f < 3; f++) begin
      fill(1, 0);
      drive_frame(6, W, 10);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
